// File: rtl/mon_pkg.sv
// Shared encodings for the data-RAM port arbiter.
// Latency: n/a. Backpressure: n/a.
package mon_pkg;

   typedef enum logic [1:0] {
      S_CPU  = 2'd0,
      S_HAND = 2'd1,
      S_MON  = 2'd2,
      S_SLOT = 2'd3
   } arb_state_t;

   localparam logic TAG_CPU = 1'b0;
   localparam logic TAG_MON = 1'b1;

endpackage

// File: rtl/arb_stat_cntr.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Latency: count visible one cycle after the event. Backpressure: none.
module arb_stat_cntr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the data-RAM port between the CPU LSU and the UART monitor (fixed priority, turnaround bubble, forced CPU slots).
// Latency: grant is combinational; read data returns one cycle after the access. Backpressure: gnt low stalls the requester. Stall counter under ARB_STAT_EN.
module dram_port_arbiter
   import mon_pkg::*;
#(
   parameter int         DWIDTH       = 14,
   parameter logic [7:0] MAX_MON_HOLD = 8'd64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DWIDTH-1:0] cpu_adr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              mon_req,
   input  logic              mon_we,
   input  logic [DWIDTH-1:0] mon_adr,
   input  logic [31:0]       mon_wdata,
   output logic              mon_gnt,
   output logic              mon_rvalid,
   output logic [31:0]       mon_rdata,
   output logic [DWIDTH-1:0] ram_radr,
   output logic              ram_ren,
   output logic [DWIDTH-1:0] ram_wadr,
   output logic [31:0]       ram_wdata,
   output logic              ram_wen,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       stall_cnt,
   input  logic              stat_clr
);

   localparam logic       FAIR_EN  = (MAX_MON_HOLD != 8'd0);
   localparam logic [7:0] HOLD_LIM = MAX_MON_HOLD - 8'd1;

   arb_state_t  state, state_nxt;
   logic [7:0]  hold_cnt, hold_nxt;
   logic        rd_pend, rd_tag;

   assign cpu_gnt   = cpu_req & ((state == S_CPU) | (state == S_SLOT));
   assign mon_gnt   = mon_req & (state == S_MON);
   assign cpu_stall = cpu_req & ~cpu_gnt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_CPU:   if (mon_req) state_nxt = S_HAND;
         S_HAND:  state_nxt = S_MON;
         S_MON: begin
            if (!mon_req)
               state_nxt = S_CPU;
            else if (FAIR_EN && cpu_req && (hold_cnt == HOLD_LIM))
               state_nxt = S_SLOT;
         end
         S_SLOT:  state_nxt = mon_req ? S_MON : S_CPU;
         default: state_nxt = S_CPU;
      endcase
   end

   // Saturating at HOLD_LIM keeps the counter from wrapping when forced slots are disabled.
   always_comb begin
      hold_nxt = hold_cnt;
      if (!cpu_req || (state_nxt == S_SLOT) || (state_nxt == S_CPU))
         hold_nxt = 8'd0;
      else if ((state == S_MON) && (hold_cnt != HOLD_LIM))
         hold_nxt = hold_cnt + 8'd1;
   end

   assign ram_radr  = mon_gnt ? mon_adr   : cpu_adr;
   assign ram_wadr  = mon_gnt ? mon_adr   : cpu_adr;
   assign ram_wdata = mon_gnt ? mon_wdata : cpu_wdata;
   assign ram_ren   = (cpu_gnt & ~cpu_we) | (mon_gnt & ~mon_we);
   assign ram_wen   = (cpu_gnt &  cpu_we) | (mon_gnt &  mon_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_CPU;
         hold_cnt <= 8'd0;
         rd_pend  <= 1'b0;
         rd_tag   <= TAG_CPU;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rd_pend  <= ram_ren;
         if (ram_ren)
            rd_tag <= mon_gnt ? TAG_MON : TAG_CPU;
      end
   end

   // Data goes to both sides; only the tagged side sees rvalid.
   assign cpu_rvalid = rd_pend & (rd_tag == TAG_CPU);
   assign mon_rvalid = rd_pend & (rd_tag == TAG_MON);
   assign cpu_rdata  = ram_rdata;
   assign mon_rdata  = ram_rdata;

`ifdef ARB_STAT_EN
   arb_stat_cntr #(.W(32)) u_stat (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stat_clr),
      .inc   (cpu_stall),
      .cnt   (stall_cnt)
   );
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stall_cnt       = 32'd0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: vector table, read-return scoreboard, fairness/stat/reset sequences.
// Second instance with forced slots disabled runs on the same stimulus.
module tb_dram_port_arbiter;
   import mon_pkg::*;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, mon_req, mon_we, stat_clr;
   logic [DW-1:0] cpu_adr, mon_adr;
   logic [31:0]   cpu_wdata, mon_wdata, ram_rdata;

   logic          cpu_gnt, cpu_stall, cpu_rvalid, mon_gnt, mon_rvalid, ram_ren, ram_wen;
   logic [31:0]   cpu_rdata, mon_rdata, ram_wdata, stall_cnt;
   logic [DW-1:0] ram_radr, ram_wadr;

   logic          z_cpu_gnt, z_cpu_stall, z_cpu_rvalid, z_mon_gnt, z_mon_rvalid, z_ram_ren, z_ram_wen;
   logic [31:0]   z_cpu_rdata, z_mon_rdata, z_ram_wdata, z_stall_cnt;
   logic [DW-1:0] z_ram_radr, z_ram_wadr;

   always #5 clk = ~clk;

   dram_port_arbiter #(.DWIDTH(DW), .MAX_MON_HOLD(8'd4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mon_req(mon_req), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
      .mon_gnt(mon_gnt), .mon_rvalid(mon_rvalid), .mon_rdata(mon_rdata),
      .ram_radr(ram_radr), .ram_ren(ram_ren), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
      .ram_wen(ram_wen), .ram_rdata(ram_rdata), .stall_cnt(stall_cnt), .stat_clr(stat_clr)
   );

   dram_port_arbiter #(.DWIDTH(DW), .MAX_MON_HOLD(8'd0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(z_cpu_gnt), .cpu_stall(z_cpu_stall), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
      .mon_req(mon_req), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
      .mon_gnt(z_mon_gnt), .mon_rvalid(z_mon_rvalid), .mon_rdata(z_mon_rdata),
      .ram_radr(z_ram_radr), .ram_ren(z_ram_ren), .ram_wadr(z_ram_wadr), .ram_wdata(z_ram_wdata),
      .ram_wen(z_ram_wen), .ram_rdata(ram_rdata), .stall_cnt(z_stall_cnt), .stat_clr(stat_clr)
   );

   // Synchronous RAM model; reads use addresses below 0x80, writes at or above 0x80.
   logic [31:0] mem [0:255];

   function automatic logic [31:0] init_word(input logic [7:0] a);
      return (a == 8'h10) ? 32'h1234_5678 : {16'h5A00, a, ~a};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(8'(i));
   end

   always @(posedge clk) begin
      if (ram_ren) ram_rdata <= mem[ram_radr[7:0]];
      if (ram_wen) mem[ram_wadr[7:0]] = ram_wdata;
   end

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_cnt;

   typedef struct {
      logic        tag;
      logic [31:0] data;
   } rd_exp_t;
   rd_exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      mon_req = 1'b0; mon_we = 1'b0; mon_adr = '0; mon_wdata = '0;
   endtask

   task automatic check_quiet(input string nm);
      chk({nm, ":gnt"},    32'({cpu_gnt, mon_gnt}),       32'd0);
      chk({nm, ":rvalid"}, 32'({cpu_rvalid, mon_rvalid}), 32'd0);
      chk({nm, ":ren_wen"},32'({ram_ren, ram_wen}),       32'd0);
      chk({nm, ":stall_cnt"}, stall_cnt, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stat_clr = 1'b0;
      drive_idle();
      sb.delete();
      exp_cnt = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1.
   task automatic cyc(input logic cr, input logic cw, input logic [DW-1:0] ca, input logic [31:0] cd,
                      input logic mr, input logic mw, input logic [DW-1:0] ma, input logic [31:0] md,
                      input logic ecg, input logic emg, input logic chk0, input logic e0cg,
                      input string nm);
      rd_exp_t e;
      logic [DW-1:0] eadr;
      cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wdata = cd;
      mon_req = mr; mon_we = mw; mon_adr = ma; mon_wdata = md;
      @(negedge clk);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({nm, ":rvalid_route"}, 32'({cpu_rvalid, mon_rvalid}), 32'({e.tag == TAG_CPU, e.tag == TAG_MON}));
         chk({nm, ":rdata"}, (e.tag == TAG_MON) ? mon_rdata : cpu_rdata, e.data);
      end else begin
         chk({nm, ":no_rvalid"}, 32'({cpu_rvalid, mon_rvalid}), 32'd0);
      end
      eadr = emg ? ma : ca;
      chk({nm, ":gnt"},   32'({cpu_gnt, mon_gnt}), 32'({ecg, emg}));
      chk({nm, ":stall"}, 32'(cpu_stall), 32'(cr & ~ecg));
      chk({nm, ":ren_wen"}, 32'({ram_ren, ram_wen}),
          32'({(ecg & ~cw) | (emg & ~mw), (ecg & cw) | (emg & mw)}));
      chk({nm, ":radr"}, 32'(ram_radr), 32'(eadr));
      chk({nm, ":wadr"}, 32'(ram_wadr), 32'(eadr));
      if ((ecg & cw) | (emg & mw))
         chk({nm, ":wdata"}, ram_wdata, emg ? md : cd);
      chk({nm, ":stall_cnt"}, stall_cnt, exp_cnt);
      if (chk0)
         chk({nm, ":nofair_cpu_gnt"}, 32'(z_cpu_gnt), 32'(e0cg));
      if (ecg & ~cw) sb.push_back('{tag: TAG_CPU, data: init_word(ca[7:0])});
      if (emg & ~mw) sb.push_back('{tag: TAG_MON, data: init_word(ma[7:0])});
`ifdef ARB_STAT_EN
      if (stat_clr) exp_cnt = 32'd0;
      else if (cr & ~ecg && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          cr, cw;
      logic [DW-1:0] ca;
      logic [31:0]   cd;
      logic          mr, mw;
      logic [DW-1:0] ma;
      logic [31:0]   md;
      logic          ecg, emg;
   } vec_t;

   vec_t tbl[16];

   initial begin
      //            cr    cw    ca       cd            mr    mw    ma       md            ecg   emg
      tbl[0]  = '{1'b0, 1'b0, 14'h000, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 14'h010, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 14'h080, 32'hDEADBEEF, 1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 14'h011, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 14'h012, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h006, 32'h0,        1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h006, 32'h0,        1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h006, 32'h0,        1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b1, 14'h081, 32'hCAFE0001, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h007, 32'h0,        1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h008, 32'h0,        1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 14'h005, 32'h0,        1'b1, 1'b0, 14'h009, 32'h0,        1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0, 14'h009, 32'h0,        1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 14'h020, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 14'h021, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 14'h000, 32'h0,        1'b0, 1'b0, 14'h000, 32'h0,        1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 16; i++)
         cyc(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].mr, tbl[i].mw, tbl[i].ma, tbl[i].md,
             tbl[i].ecg, tbl[i].emg, 1'b0, 1'b0, $sformatf("row%0d", i));

      // Fairness: hold 4 gives 4 monitor grants then one CPU slot; hold 0 never yields.
      do_reset();
      for (int c = 0; c < 17; c++) begin
         cyc(1'b1, 1'b1, 14'h090, 32'(c), 1'b1, 1'b1, 14'h091, 32'(c),
             (c == 0) || (c >= 2 && (c - 2) % 5 == 4), (c >= 2 && (c - 2) % 5 < 4),
             1'b1, (c == 0), $sformatf("fair%0d", c));
      end
      cyc(1'b1, 1'b1, 14'h090, 32'h11, 1'b0, 1'b0, 14'h000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "mon_drop");
      cyc(1'b1, 1'b1, 14'h090, 32'h12, 1'b0, 1'b0, 14'h000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, "after_drop");

      // Stall statistics: ten stall cycles, then clear coinciding with a stall.
      do_reset();
      cyc(1'b0, 1'b0, 14'h000, 32'h0, 1'b1, 1'b1, 14'h0A0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, "st_det");
      cyc(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, "st_hand");
      for (int c = 0; c < 4; c++)
         cyc(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A0, 32'(c), 1'b0, 1'b1, 1'b0, 1'b0, "st_mon_a");
      cyc(1'b0, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A0, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, "st_slot");
      for (int c = 0; c < 3; c++)
         cyc(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A1, 32'(c), 1'b0, 1'b1, 1'b0, 1'b0, "st_mon_b");
      cyc(1'b0, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, "st_nocpu");
      for (int c = 0; c < 2; c++)
         cyc(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A2, 32'(c), 1'b0, 1'b1, 1'b0, 1'b0, "st_mon_c");
`ifdef ARB_STAT_EN
      chk("stall10", stall_cnt, 32'd10);
`else
      chk("stall10_disabled", stall_cnt, 32'd0);
`endif
      stat_clr = 1'b1;
      cyc(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b1, 14'h0A2, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0, "st_clr");
      stat_clr = 1'b0;
      chk("stat_clr", stall_cnt, 32'd0);
      cyc(1'b0, 1'b0, 14'h000, 32'h0, 1'b0, 1'b0, 14'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "st_end");

      // Reset mid-burst with a monitor read in flight.
      do_reset();
      cyc(1'b0, 1'b0, 14'h000, 32'h0, 1'b1, 1'b0, 14'h006, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "rb_det");
      cyc(1'b1, 1'b0, 14'h002, 32'h0, 1'b1, 1'b0, 14'h006, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "rb_hand");
      cyc(1'b1, 1'b0, 14'h002, 32'h0, 1'b1, 1'b0, 14'h007, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, "rb_mon");
      #2;
      rst_n   = 1'b0;
      cpu_req = 1'b0;
      #1;
      check_quiet("midreset");
      sb.delete();
      do_reset();
      cyc(1'b1, 1'b0, 14'h013, 32'h0, 1'b0, 1'b0, 14'h000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
      cyc(1'b0, 1'b0, 14'h000, 32'h0, 1'b0, 1'b0, 14'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "post_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
